lstm_weight_stream_src: RTL and testbench

Simulation/bring-up weight source for the LSTM accelerator. It generates the complete packed LSTM weight image: all input-to-hidden (W_ih) weights followed by all hidden-to-hidden (W_hh) weights for the four gates. The image is produced arithmetically, with no stored ROM, and streamed one QZ-bit word per read request into the weight-save FIFO. It replaces a 1.2 M-entry weight memory during integration tests.

---
 rtl/lstm_weight_stream_src.sv | 115 +++++++++++
 tb/tb_lstm_weight_stream_src.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_weight_stream_src.sv
// lstm_weight_stream_src
// Arithmetic LSTM weight-image source: streams the packed W_ih then W_hh
// weights for all four gates, one QZ-bit word (two QZ/2-bit weights) per
// read request. No storage; every word is computed from its index.
// Optional macro WEIGHT_RA_PORT_EN adds a random-access read port
// (ra_en / ra_addr) that has priority over sequential streaming.
module lstm_weight_stream_src #(
  parameter int unsigned COL   = 512,
  parameter int unsigned COW   = 96,
  parameter int unsigned QZ    = 16,
  parameter int unsigned DEBUG = 1,
  localparam int unsigned N_WORDS = (4 * COW * COL + 4 * COL * COL) / 2,
  localparam int unsigned AW      = $clog2(N_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
`ifdef WEIGHT_RA_PORT_EN
  input  logic          ra_en,
  input  logic [AW-1:0] ra_addr,
`endif
  output logic [QZ-1:0] data_out,
  output logic          data_valid,
  output logic [AW-1:0] addr_o,
  output logic          region_hh,
  output logic          last,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned   HW     = QZ / 2;
  localparam int unsigned   B_IDX  = 4 * COW * COL;
  localparam logic [AW-1:0] LAST_A = AW'(N_WORDS - 1);

  // Weight value for weight index k.
  function automatic logic [HW-1:0] weight_at(input logic [63:0] k);
    if (DEBUG != 0)
      return HW'(1);
    else if (k < 64'(B_IDX))
      return k[HW-1:0];
    else
      return ~k[HW-1:0];
  endfunction

  logic [AW-1:0] ptr;
  logic          emit;
  logic          advance;
  logic [AW-1:0] emit_addr;
  logic          emit_oob;
  logic [63:0]   k0;
  logic [63:0]   k1;
  logic [QZ-1:0] emit_word;
  logic          emit_hh;
  logic          emit_last;

  // Select which word (if any) is emitted this cycle and compute its contents.
  always_comb begin
    emit      = rd_en;
    advance   = rd_en;
    emit_addr = ptr;
    emit_oob  = 1'b0;
`ifdef WEIGHT_RA_PORT_EN
    if (ra_en) begin
      emit      = 1'b1;
      advance   = 1'b0;
      emit_addr = ra_addr;
      emit_oob  = (32'(ra_addr) >= N_WORDS);
    end
`endif
    k0        = 64'(emit_addr) << 1;
    k1        = k0 + 64'd1;
    emit_word = {weight_at(k1), weight_at(k0)};
    emit_hh   = (k0 >= 64'(B_IDX));
    emit_last = (emit_addr == LAST_A);
    if (emit_oob) begin
      emit_word = '0;
      emit_hh   = 1'b0;
      emit_last = 1'b0;
    end
  end

  // Sequential word pointer and completed-image counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      frame_cnt <= '0;
    end else if (advance) begin
      if (ptr == LAST_A) begin
        ptr       <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // Output register: strobes pulse per word, payload holds between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      addr_o     <= '0;
      region_hh  <= 1'b0;
      last       <= 1'b0;
    end else begin
      data_valid <= emit;
      last       <= emit & emit_last;
      if (emit) begin
        data_out  <= emit_word;
        addr_o    <= emit_addr;
        region_hh <= emit_hh;
      end
    end
  end

endmodule

// File: tb/tb_lstm_weight_stream_src.sv
// Bench for lstm_weight_stream_src at reduced size (COL=8, COW=4, QZ=16:
// N=192 words, boundary at word 64). Two instances, DEBUG=1 and DEBUG=0,
// share the stimulus; a behavioural model predicts both every cycle.
module tb_lstm_weight_stream_src;

  localparam int N  = 192;
  localparam int B  = 128;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_en = 1'b0;
  logic ra_en = 1'b0;
  logic [AW-1:0] ra_addr = '0;

  logic [15:0]   d1_data,  d0_data;
  logic          d1_valid, d0_valid;
  logic [AW-1:0] d1_addr,  d0_addr;
  logic          d1_hh,    d0_hh;
  logic          d1_last,  d0_last;
  logic [15:0]   d1_frame, d0_frame;

  logic [15:0]   e_d1, e_d0;
  logic          e_valid, e_hh, e_last;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_frame;
  int m_ptr = 0;
  int m_frame = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lstm_weight_stream_src #(.COL(8), .COW(4), .QZ(16), .DEBUG(1)) u_dbg (
    .clk(clk), .rst(rst), .rd_en(rd_en),
`ifdef WEIGHT_RA_PORT_EN
    .ra_en(ra_en), .ra_addr(ra_addr),
`endif
    .data_out(d1_data), .data_valid(d1_valid), .addr_o(d1_addr),
    .region_hh(d1_hh), .last(d1_last), .frame_cnt(d1_frame)
  );

  lstm_weight_stream_src #(.COL(8), .COW(4), .QZ(16), .DEBUG(0)) u_idx (
    .clk(clk), .rst(rst), .rd_en(rd_en),
`ifdef WEIGHT_RA_PORT_EN
    .ra_en(ra_en), .ra_addr(ra_addr),
`endif
    .data_out(d0_data), .data_valid(d0_valid), .addr_o(d0_addr),
    .region_hh(d0_hh), .last(d0_last), .frame_cnt(d0_frame)
  );

  // Packed word from the weight rules: two 8-bit weights, low = even index.
  function automatic logic [15:0] model_word(input int a, input bit dbg);
    int w [2];
    int k;
    for (int j = 0; j < 2; j++) begin
      k = 2 * a + j;
      if (dbg)        w[j] = 1;
      else if (k < B) w[j] = k % 256;
      else            w[j] = 255 - (k % 256);
    end
    return 16'(w[1] * 256 + w[0]);
  endfunction

  // Advance the model by one clock using the inputs sampled at that edge.
  function automatic void model_step();
    int  e;
    bit  emit;
    bit  adv;
    if (rst) begin
      e_d1 = '0; e_d0 = '0; e_valid = 1'b0; e_hh = 1'b0; e_last = 1'b0;
      e_addr = '0; e_frame = '0; m_ptr = 0; m_frame = 0;
      return;
    end
    emit = 1'b0; adv = 1'b0; e = 0;
    if (ra_en) begin
      emit = 1'b1; e = int'(ra_addr);
    end else if (rd_en) begin
      emit = 1'b1; adv = 1'b1; e = m_ptr;
    end
    e_valid = emit;
    e_last  = 1'b0;
    if (emit) begin
      e_addr = AW'(e);
      if (e >= N) begin
        e_d1 = '0; e_d0 = '0; e_hh = 1'b0;
      end else begin
        e_d1   = model_word(e, 1'b1);
        e_d0   = model_word(e, 1'b0);
        e_hh   = (2 * e >= B);
        e_last = (e == N - 1);
      end
    end
    if (adv) begin
      if (m_ptr == N - 1) m_frame = (m_frame + 1) % 65536;
      m_ptr = (m_ptr + 1) % N;
    end
    e_frame = 16'(m_frame);
  endfunction

  function automatic logic [85:0] obs_vec();
    return {d1_data, d1_valid, d1_addr, d1_hh, d1_last, d1_frame,
            d0_data, d0_valid, d0_addr, d0_hh, d0_last, d0_frame};
  endfunction

  function automatic logic [85:0] exp_vec();
    return {e_d1, e_valid, e_addr, e_hh, e_last, e_frame,
            e_d0, e_valid, e_addr, e_hh, e_last, e_frame};
  endfunction

  task automatic tick(input logic r, input logic rd, input logic rae,
                      input logic [AW-1:0] raa);
    @(negedge clk);
    rst = r; rd_en = rd; ra_en = rae; ra_addr = raa;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (obs_vec() !== 86'b0) begin
      errors++; $display("FAIL reset_all got %h expected 0", obs_vec());
    end
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (d0_valid !== 1'b0 || d1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_valid got %b/%b expected 0", d1_valid, d0_valid);
    end
  endtask

  task automatic test_first_word();
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({d1_data, d0_data, d0_addr, d0_valid, d0_hh} !== {16'h0101, 16'h0100, 8'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL first_word got %h %h a=%0d v=%b hh=%b expected 0101 0100 a=0 v=1 hh=0",
               d1_data, d0_data, d0_addr, d0_valid, d0_hh);
    end
    tick(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (d0_valid !== 1'b0 || d0_data !== 16'h0100 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL first_word_hold got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_region_boundary();
    int guard = 0;
    while (m_ptr != 63 && guard < 2 * N) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      guard++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL boundary_stream got %h expected %h", obs_vec(), exp_vec());
      end
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({d0_data, d0_addr, d0_hh} !== {16'h7F7E, 8'd63, 1'b0}) begin
      errors++; $display("FAIL word_63 got %h a=%0d hh=%b expected 7f7e a=63 hh=0", d0_data, d0_addr, d0_hh);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({d0_data, d0_addr, d0_hh, d1_data} !== {16'h7E7F, 8'd64, 1'b1, 16'h0101}) begin
      errors++;
      $display("FAIL word_64 got %h a=%0d hh=%b dbg=%h expected 7e7f a=64 hh=1 dbg=0101",
               d0_data, d0_addr, d0_hh, d1_data);
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    int f0;
    while (m_ptr != N - 1 && guard < 2 * N) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      guard++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL image_stream got %h expected %h", obs_vec(), exp_vec());
      end
    end
    f0 = m_frame;
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({d0_data, d0_addr, d0_last, d0_hh, d0_frame} !== {16'h8081, 8'd191, 1'b1, 1'b1, 16'(f0 + 1)}) begin
      errors++;
      $display("FAIL last_word got %h a=%0d last=%b hh=%b fc=%0d expected 8081 a=191 last=1 hh=1 fc=%0d",
               d0_data, d0_addr, d0_last, d0_hh, d0_frame, f0 + 1);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({d0_data, d0_addr, d0_last, d0_hh, d0_valid} !== {16'h0100, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_word0 got %h a=%0d last=%b hh=%b v=%b expected 0100 a=0 last=0 hh=0 v=1",
               d0_data, d0_addr, d0_last, d0_hh, d0_valid);
    end
  endtask

  task automatic test_stall();
    int p;
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b0, '0);
    p = m_ptr;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (d0_valid !== 1'b0 || d0_addr !== AW'(p - 1) || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_freeze got %h expected %h", obs_vec(), exp_vec());
      end
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (d0_valid !== 1'b1 || d0_addr !== AW'(p) || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL stall_resume got a=%0d v=%b expected a=%0d v=1", d0_addr, d0_valid, p);
    end
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (m_ptr != 100 && guard < 2 * N) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      guard++;
    end
    tick(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (obs_vec() !== 86'b0) begin
      errors++; $display("FAIL mid_reset got %h expected 0", obs_vec());
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({d0_data, d0_addr, d0_valid, d0_frame} !== {16'h0100, 8'd0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL after_reset got %h a=%0d v=%b fc=%0d expected 0100 a=0 v=1 fc=0",
               d0_data, d0_addr, d0_valid, d0_frame);
    end
  endtask

  task automatic test_random();
    logic r, rd, rae;
    logic [AW-1:0] raa;
    for (int i = 0; i < 900; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 9) < 8);
      rae = 1'b0;
      raa = AW'($urandom_range(0, 255));
`ifdef WEIGHT_RA_PORT_EN
      rae = ($urandom_range(0, 9) == 0);
`endif
      tick(r, rd, rae, raa);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle_%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

`ifdef WEIGHT_RA_PORT_EN
  task automatic test_ra();
    int p;
    int f;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, '0);
    p = m_ptr;
    f = m_frame;
    tick(1'b0, 1'b1, 1'b1, 8'd64);
    checks++;
    if ({d0_data, d0_hh, d0_addr, d0_valid} !== {16'h7E7F, 1'b1, 8'd64, 1'b1}) begin
      errors++; $display("FAIL ra_word64 got %h hh=%b a=%0d expected 7e7f hh=1 a=64", d0_data, d0_hh, d0_addr);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (d0_addr !== AW'(p)) begin
      errors++; $display("FAIL ra_ptr_hold got a=%0d expected a=%0d", d0_addr, p);
    end
    tick(1'b0, 1'b0, 1'b1, 8'd250);
    checks++;
    if ({d0_data, d0_valid, d0_hh, d0_last} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ra_oob got %h v=%b hh=%b last=%b expected 0000 v=1 hh=0 last=0",
                         d0_data, d0_valid, d0_hh, d0_last);
    end
    tick(1'b0, 1'b1, 1'b1, 8'd191);
    checks++;
    if ({d0_data, d0_last, d0_frame} !== {16'h8081, 1'b1, 16'(f)}) begin
      errors++; $display("FAIL ra_last got %h last=%b fc=%0d expected 8081 last=1 fc=%0d",
                         d0_data, d0_last, d0_frame, f);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_region_boundary();
    test_back_to_back();
    test_stall();
    test_mid_reset();
`ifdef WEIGHT_RA_PORT_EN
    test_ra();
`endif
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
